config_shadow_chain: RTL and testbench

//  Parametrised, double-buffered configuration shift chain for routing tiles (connection/switch blocks).

---
 rtl/config_shadow_chain_if.sv | 54 +++++
 rtl/config_shadow_chain.sv | 105 ++++++++++
 tb/tb_config_shadow_chain.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/config_shadow_chain_if.sv
// ============================================================================
// Module : config_shadow_chain_if
// Brief  : Chain, commit and status signals of one config shadow chain tile.
//          cfg_parity exists only when CONFIG_PARITY_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface config_shadow_chain_if #(
    parameter int CONF_WIDTH = 64,
    parameter int LANES      = 1
);
    logic                  cen;
    logic                  set_in;
    logic [LANES-1:0]      shift_in;
`ifdef CONFIG_PARITY_EN
    logic                  cfg_parity;
`endif
    logic [LANES-1:0]      shift_out;
    logic [CONF_WIDTH-1:0] conf_active;
    logic                  loaded;
    logic                  frame_done;
    logic                  commit_err;

    modport master (
`ifdef CONFIG_PARITY_EN
        output cfg_parity,
`endif
        output cen,
        output set_in,
        output shift_in,
        input  shift_out,
        input  conf_active,
        input  loaded,
        input  frame_done,
        input  commit_err
    );

    modport slave (
`ifdef CONFIG_PARITY_EN
        input  cfg_parity,
`endif
        input  cen,
        input  set_in,
        input  shift_in,
        output shift_out,
        output conf_active,
        output loaded,
        output frame_done,
        output commit_err
    );
endinterface

`default_nettype wire

// File: rtl/config_shadow_chain.sv
// ============================================================================
// Module : config_shadow_chain
// Brief  : Double-buffered routing config shift chain with frame counter and
//          guarded commit. Optional macro CONFIG_PARITY_EN adds a parity check
//          on commit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module config_shadow_chain #(
    parameter int CONF_WIDTH = 64,
    parameter int LANES      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    config_shadow_chain_if.slave bus
);

    localparam int c_BEATS = CONF_WIDTH / LANES;
    localparam int c_CNT_W = $clog2(c_BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_BEATS_CNT = c_CNT_W'(c_BEATS);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_count;
    logic [CONF_WIDTH-1:0] r_shadow;
    logic [CONF_WIDTH-1:0] r_active;
    logic                  r_frame_done;
    logic                  r_commit_err;

    logic [CONF_WIDTH-1:0] w_shadow_shifted;
    logic [c_CNT_W-1:0]    w_count_inc;
    logic                  w_parity_ok;
    logic                  w_commit_ok;

    // New lanes enter at the top so the first beat of a frame lands in the low bits.
    generate
        if (LANES < CONF_WIDTH) begin : g_multi_beat
            assign w_shadow_shifted = {bus.shift_in, r_shadow[CONF_WIDTH-1:LANES]};
        end else begin : g_single_beat
            assign w_shadow_shifted = bus.shift_in;
        end
    endgenerate

`ifdef CONFIG_PARITY_EN
    assign w_parity_ok = ((^r_shadow) == bus.cfg_parity);
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_count_inc = r_count + c_CNT_W'(1);
    assign w_commit_ok = (r_state == S_FULL) && w_parity_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_EMPTY;
            r_count      <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_frame_done <= 1'b0;
            r_commit_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.set_in) begin
                // Commit takes priority over a coincident shift beat.
                if (w_commit_ok) begin
                    r_active     <= r_shadow;
                    r_count      <= '0;
                    r_state      <= S_EMPTY;
                    r_commit_err <= 1'b0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_commit_err <= 1'b1;
                end
            end else if (bus.cen) begin
                r_shadow <= w_shadow_shifted;
                case (r_state)
                    S_EMPTY, S_LOADING: begin
                        r_count <= w_count_inc;
                        r_state <= (w_count_inc == c_BEATS_CNT) ? S_FULL : S_LOADING;
                    end
                    default: begin
                        // Full: keep passing data through, count stays saturated.
                        r_count <= r_count;
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign bus.shift_out   = r_shadow[LANES-1:0];
    assign bus.conf_active = r_active;
    assign bus.loaded      = (r_state == S_FULL);
    assign bus.frame_done  = r_frame_done;
    assign bus.commit_err  = r_commit_err;

endmodule

`default_nettype wire

// File: tb/tb_config_shadow_chain.sv
// ============================================================================
// Module : tb_config_shadow_chain
// Brief  : Directed self-checking bench for config_shadow_chain (8 bits, 2 lanes).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_config_shadow_chain;

    localparam int CONF_WIDTH = 8;
    localparam int LANES      = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    config_shadow_chain_if #(.CONF_WIDTH(CONF_WIDTH), .LANES(LANES)) bus ();

    config_shadow_chain #(.CONF_WIDTH(CONF_WIDTH), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [LANES-1:0] d);
        bus.cen      = 1'b1;
        bus.set_in   = 1'b0;
        bus.shift_in = d;
        @(posedge clk);
        #1;
        bus.cen      = 1'b0;
    endtask

    task automatic commit();
        bus.set_in = 1'b1;
        @(posedge clk);
        #1;
        bus.set_in = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst          = 1'b0;
        bus.cen      = 1'b0;
        bus.set_in   = 1'b0;
        bus.shift_in = '0;
`ifdef CONFIG_PARITY_EN
        bus.cfg_parity = 1'b0;
`endif
        #12;
        check_val("rst_conf",   bus.conf_active, 64'h00);
        check_val("rst_sout",   bus.shift_out,   64'h0);
        check_val("rst_loaded", bus.loaded,      64'h0);
        check_val("rst_fdone",  bus.frame_done,  64'h0);
        check_val("rst_err",    bus.commit_err,  64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Load 01,10,11,00 and commit -> 0x39
        beat(2'b01); beat(2'b10); beat(2'b11);
        check_val("t2_loaded_b3", bus.loaded, 64'h0);
        beat(2'b00);
        check_val("t2_loaded_b4", bus.loaded,    64'h1);
        check_val("t2_sout_b4",   bus.shift_out, 64'h1);
        check_val("t2_conf_pre",  bus.conf_active, 64'h00);
        commit();
        check_val("t2_conf",   bus.conf_active, 64'h39);
        check_val("t2_fdone",  bus.frame_done,  64'h1);
        check_val("t2_loaded", bus.loaded,      64'h0);
        check_val("t2_err",    bus.commit_err,  64'h0);
        idle();
        check_val("t2_fdone_end", bus.frame_done, 64'h0);

        // Short frame refused, then a full frame clears the error
        beat(2'b01); beat(2'b10); beat(2'b11);
        commit();
        check_val("t3_err",    bus.commit_err,  64'h1);
        check_val("t3_conf",   bus.conf_active, 64'h39);
        check_val("t3_loaded", bus.loaded,      64'h0);
        check_val("t3_fdone",  bus.frame_done,  64'h0);
        beat(2'b11); beat(2'b10); beat(2'b01); beat(2'b00);
        check_val("t3_loaded_full", bus.loaded, 64'h1);
        commit();
        check_val("t3_conf2", bus.conf_active, 64'h1B);
        check_val("t3_err2",  bus.commit_err,  64'h0);
        idle();

        // Overshift: 6 beats, count saturates, data passes through
        beat(2'b01); beat(2'b10); beat(2'b11); beat(2'b00);
        check_val("t4_sout_b5", bus.shift_out, 64'h1);
        beat(2'b01);
        check_val("t4_sout_b6", bus.shift_out, 64'h2);
        check_val("t4_loaded5", bus.loaded,    64'h1);
        check_val("t4_conf_hold", bus.conf_active, 64'h1B);
        beat(2'b10);
        check_val("t4_loaded6", bus.loaded,    64'h1);
        check_val("t4_sout_end", bus.shift_out, 64'h3);
        commit();
        check_val("t4_conf", bus.conf_active, 64'h93);
        idle();

        // Collision: cen and set_in together, set wins and shadow is untouched
        beat(2'b01); beat(2'b10); beat(2'b10); beat(2'b10);
        check_val("t5_sout_pre", bus.shift_out, 64'h1);
        bus.cen      = 1'b1;
        bus.set_in   = 1'b1;
        bus.shift_in = 2'b11;
        idle();
        bus.cen      = 1'b0;
        bus.set_in   = 1'b0;
        check_val("t5_conf",   bus.conf_active, 64'hA9);
        check_val("t5_sout",   bus.shift_out,   64'h1);
        check_val("t5_loaded", bus.loaded,      64'h0);
        check_val("t5_fdone",  bus.frame_done,  64'h1);
        idle();

        // set_in held two cycles: commit then refusal
        beat(2'b00); beat(2'b00); beat(2'b11); beat(2'b11);
        bus.set_in = 1'b1;
        idle();
        check_val("t5h_conf1",  bus.conf_active, 64'hF0);
        check_val("t5h_err1",   bus.commit_err,  64'h0);
        check_val("t5h_fdone1", bus.frame_done,  64'h1);
        idle();
        bus.set_in = 1'b0;
        check_val("t5h_err2",   bus.commit_err,  64'h1);
        check_val("t5h_fdone2", bus.frame_done,  64'h0);
        check_val("t5h_conf2",  bus.conf_active, 64'hF0);

        // Asynchronous reset mid-load
        beat(2'b01); beat(2'b01);
        #2;
        rst = 1'b0;
        #1;
        check_val("t1_conf",   bus.conf_active, 64'h00);
        check_val("t1_sout",   bus.shift_out,   64'h0);
        check_val("t1_loaded", bus.loaded,      64'h0);
        check_val("t1_fdone",  bus.frame_done,  64'h0);
        check_val("t1_err",    bus.commit_err,  64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        beat(2'b11); beat(2'b11); beat(2'b11);
        check_val("t1_count_cleared", bus.loaded, 64'h0);
        beat(2'b11);
        check_val("t1_refill", bus.loaded, 64'h1);

`ifdef CONFIG_PARITY_EN
        // Parity-guarded commit of frame 0x39 (even number of ones)
        beat(2'b01); beat(2'b10); beat(2'b11); beat(2'b00);
        bus.cfg_parity = 1'b1;
        commit();
        check_val("t6_err",    bus.commit_err,  64'h1);
        check_val("t6_conf",   bus.conf_active, 64'h00);
        check_val("t6_loaded", bus.loaded,      64'h1);
        check_val("t6_fdone",  bus.frame_done,  64'h0);
        bus.cfg_parity = 1'b0;
        commit();
        check_val("t6_conf2",  bus.conf_active, 64'h39);
        check_val("t6_err2",   bus.commit_err,  64'h0);
        check_val("t6_fdone2", bus.frame_done,  64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
